link_arbiter: RTL and testbench
===============================

# link_arbiter

Shares the single outbound serial link of a station (data, serial clock, ready-to-transmit GPIO lines) between two local byte sources, the scanner and the transfer center. Arbitrates round-robin, waits for the remote station's ready, and serializes the winner's byte MSB-first with a self-generated serial clock. Sits between the two requesters and the outbound GPIO pins, replacing direct pin drive by either block.

## Interface
- DATA_W, 8: bits per transfer.
- HALF, 2: serial-clock half-period in clk cycles (≥1).
- TIMEOUT, 255: max clk cycles waiting for peer_ready before abort (≥1).

- clk  in  1  system clock (divided station clock), rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  2  per-requester transfer request; bit 0 scanner, bit 1 transfer center; level, held until done/err.
- data0  in  DATA_W  scanner byte; sampled only on grant.
- data1  in  DATA_W  transfer-center byte; sampled only on grant.
- peer_ready  in  1  remote station ready-for-transfer.
- grant  out  2  one-hot owner of the link; 0 when idle.
- done  out  2  one-cycle pulse to the owner after last bit.
- err  out  2  one-cycle pulse to the owner on timeout abort.
- busy  out  1  high in any state other than IDLE.
- ser_data  out  1  serial data line.
- ser_clk  out  1  serial clock; receiver samples on rising edge.
- ser_rdy  out  1  ready-to-transmit line.

## Operation
- States: IDLE, WAIT, SHIFT, DONE, ABORT.
- IDLE: if req≠0, pick winner; next cycle WAIT, grant registered one-hot, winner's data loaded into shift register, wait counter cleared.
- Round-robin: both requesting → grant the one not granted last; single request → grant it. Pointer updates on every grant (including later abort). After reset, requester 0 wins a tie.
- WAIT: ser_rdy=1. peer_ready sampled high → SHIFT next cycle. Counter reaching TIMEOUT without peer_ready → ABORT.
- SHIFT: per bit, HALF cycles ser_clk=0 with ser_data=current bit, then HALF cycles ser_clk=1 with ser_data unchanged; shift after high phase. DATA_W bits MSB-first, then DONE.
- DONE (1 cycle): done[owner]=1, grant still held, ser_rdy=0, ser_clk=0; then IDLE, grant=0.
- ABORT (1 cycle): err[owner]=1, ser_rdy=0; then IDLE.
- req deassert before grant: withdrawn, no effect. After grant: ignored; transfer completes.
- peer_ready checked only in WAIT; changes during SHIFT ignored.
- Reset mid-transfer: all outputs to reset values immediately; partial byte discarded; no done/err.

## Timing
- Reset values: grant=0, done=0, err=0, busy=0, ser_data=0, ser_clk=0, ser_rdy=0, pointer favours 0.
- All outputs registered.
- req high at edge N (IDLE), peer_ready already high: grant/ser_rdy at N+1, SHIFT entered N+2, first ser_clk rise N+2+HALF, last fall N+2+2·HALF·DATA_W (DONE), done pulse that cycle, IDLE at +1.
- Byte duration in SHIFT: 2·HALF·DATA_W cycles (32 at defaults).
- Minimum turnaround between transfers: DONE + IDLE = 2 cycles with no serial activity.
- Timeout: ABORT entered exactly TIMEOUT cycles after WAIT entry.

## Structure
- Shared package link_pkg: state enum, requester index constants (REQ_SCAN=0, REQ_XFER=1), DATA_W default.
- One sub-module link_serializer: shift register, bit counter, phase counter; ports load, start, data, ser_data, ser_clk, last_bit. Arbiter FSM, pointer and timeout counter in the top.

## Test plan
- req=01, data0=0xA5, peer_ready=1 → grant=01, ser_data bits 1,0,1,0,0,1,0,1 at ser_clk rises, done=01 at cycle N+34.
- req=11 from reset, repeatedly held → grants alternate 01,10,01; data1=0x3C sent on second transfer.
- req=10, peer_ready=0 throughout → ser_rdy=1 for 255 cycles, err=10 pulse, grant=0, next tie goes to requester 0.
- peer_ready rises 10 cycles after grant, drops during bit 4 → transfer completes unaltered, done pulse.
- rst_n low during bit 3 → all outputs 0 same cycle; after release with req=01, full fresh byte sent.
- req=01 dropped 2 cycles after grant → transfer still completes, done=01; req pulsed low for 1 cycle in IDLE only → no grant.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the outbound link arbiter: FSM state encoding,
// requester indices and the round-robin pick helper.
package link_pkg;

    localparam int DATA_W_DEF = 8;

    // Requester index into req/grant/done/err
    localparam int REQ_SCAN = 0;
    localparam int REQ_XFER = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } link_state_e;

    // One-hot round-robin pick. prio selects the tie winner (0 = scanner).
    function automatic logic [1:0] rr_pick(input logic [1:0] req_v, input logic prio);
        logic [1:0] pick;
        pick = 2'b00;
        case (req_v)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = prio ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/link_serializer.sv
// MSB-first serializer with a self-generated serial clock. Each bit is held
// for HALF cycles with ser_clk low and HALF cycles with ser_clk high; the
// register shifts after the high phase. last_bit flags the final cycle of
// the final bit so the owner FSM can leave its shift state on time.
module link_serializer
    import link_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int HALF   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              last_bit
);

    localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shift_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [PH_W-1:0]   phase_cnt_r;
    logic              active_r;
    logic              ser_clk_r;
    logic              ser_data_r;
    logic              phase_end_s;
    logic              last_bit_s;

    // End of a half-period and end of the whole byte
    always_comb begin
        phase_end_s = active_r && (phase_cnt_r == PH_W'(HALF - 1));
        last_bit_s  = phase_end_s && ser_clk_r && (bit_cnt_r == BIT_W'(DATA_W - 1));
    end

    // Shift register, bit/phase counters and serial line drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            phase_cnt_r <= '0;
            active_r    <= 1'b0;
            ser_clk_r   <= 1'b0;
            ser_data_r  <= 1'b0;
        end else if (load) begin
            shift_r     <= data;
            bit_cnt_r   <= '0;
            phase_cnt_r <= '0;
            active_r    <= 1'b0;
            ser_clk_r   <= 1'b0;
            ser_data_r  <= 1'b0;
        end else if (start) begin
            bit_cnt_r   <= '0;
            phase_cnt_r <= '0;
            active_r    <= 1'b1;
            ser_clk_r   <= 1'b0;
            ser_data_r  <= shift_r[DATA_W-1];
        end else if (active_r) begin
            if (phase_end_s) begin
                phase_cnt_r <= '0;
                if (!ser_clk_r) begin
                    ser_clk_r <= 1'b1;
                end else if (last_bit_s) begin
                    ser_clk_r  <= 1'b0;
                    ser_data_r <= 1'b0;
                    active_r   <= 1'b0;
                end else begin
                    ser_clk_r  <= 1'b0;
                    shift_r    <= {shift_r[DATA_W-2:0], 1'b0};
                    ser_data_r <= shift_r[DATA_W-2];
                    bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
                end
            end else begin
                phase_cnt_r <= phase_cnt_r + PH_W'(1);
            end
        end else begin
            shift_r <= shift_r;
        end
    end

    assign ser_data = ser_data_r;
    assign ser_clk  = ser_clk_r;
    assign last_bit = last_bit_s;

endmodule

// File: rtl/link_arbiter.sv
// Outbound link arbiter: round-robin between scanner (0) and transfer
// center (1), handshake with the remote station via ser_rdy/peer_ready,
// then serialize the winner's byte. Abort to the owner if the peer never
// becomes ready within TIMEOUT cycles of entering WAIT.
module link_arbiter
    import link_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int HALF    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              peer_ready,
    output logic [1:0]        grant,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic              busy,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              ser_rdy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    link_state_e       state_r;
    link_state_e       state_nxt_s;
    logic [1:0]        grant_r;
    logic [1:0]        done_r;
    logic [1:0]        err_r;
    logic              busy_r;
    logic              ser_rdy_r;
    logic              prio_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [1:0]        pick_s;
    logic [DATA_W-1:0] load_data_s;
    logic              load_s;
    logic              start_s;
    logic              ser_last_s;

    // Next-state decode, arbitration pick and serializer strobes
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        start_s     = 1'b0;
        pick_s      = rr_pick(req, prio_r);
        if (pick_s[REQ_XFER]) begin
            load_data_s = data1;
        end else begin
            load_data_s = data0;
        end
        case (state_r)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_nxt_s = ST_WAIT;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (peer_ready) begin
                    state_nxt_s = ST_SHIFT;
                    start_s     = 1'b1;
                end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_SHIFT: begin
                if (ser_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            ST_ABORT: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and status outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            ser_rdy_r <= 1'b0;
            done_r    <= 2'b00;
            err_r     <= 2'b00;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            ser_rdy_r <= (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_SHIFT);
            done_r    <= (state_nxt_s == ST_DONE)  ? grant_r : 2'b00;
            err_r     <= (state_nxt_s == ST_ABORT) ? grant_r : 2'b00;
        end
    end

    // Grant ownership and round-robin pointer; pointer moves on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r <= 2'b00;
            prio_r  <= 1'b0;
        end else if (load_s) begin
            grant_r <= pick_s;
            prio_r  <= pick_s[REQ_SCAN];
        end else if (state_nxt_s == ST_IDLE) begin
            grant_r <= 2'b00;
        end else begin
            grant_r <= grant_r;
        end
    end

    // Peer-ready wait counter, cleared on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (load_s) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    link_serializer #(
        .DATA_W (DATA_W),
        .HALF   (HALF)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .start    (start_s),
        .data     (load_data_s),
        .ser_data (ser_data),
        .ser_clk  (ser_clk),
        .last_bit (ser_last_s)
    );

    assign grant   = grant_r;
    assign done    = done_r;
    assign err     = err_r;
    assign busy    = busy_r;
    assign ser_rdy = ser_rdy_r;

endmodule

// File: tb/tb_link_arbiter.sv
// Directed bench for link_arbiter at default parameters (DATA_W=8, HALF=2,
// TIMEOUT=255). Inputs change and outputs are sampled on the falling edge.
// Cycle numbering inside run_xfer: cycle 0 is the cycle in which req is
// presented in IDLE, cycle 1 shows the grant.
module tb_link_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       peer_ready;
    logic [1:0] grant;
    logic [1:0] done;
    logic [1:0] err;
    logic       busy;
    logic       ser_data;
    logic       ser_clk;
    logic       ser_rdy;

    int n_vec;
    int n_miss;

    link_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .peer_ready (peer_ready),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_rdy    (ser_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Run one transfer from IDLE, collecting bits on ser_clk rises until
    // done or err pulses, then step into the following IDLE cycle.
    task automatic run_xfer(input string tag, input logic [1:0] exp_owner,
                            input logic [7:0] exp_byte, input int exp_cyc,
                            input bit abort,
                            input int ra_cyc, input logic [1:0] ra_val,
                            input int rb_cyc, input logic [1:0] rb_val,
                            input int rdy_on, input int rdy_off);
        int         cyc;
        int         nbits;
        int         rdy_cnt;
        logic [7:0] got;
        logic       prev_clk;
        cyc      = 0;
        nbits    = 0;
        rdy_cnt  = 0;
        got      = 8'h00;
        prev_clk = ser_clk;
        while ((done == 2'b00) && (err == 2'b00) && (cyc < 600)) begin
            tick();
            cyc++;
            if (cyc == 1) check_val({tag, "_grant"}, {30'd0, grant}, {30'd0, exp_owner});
            if (ser_rdy) rdy_cnt++;
            if (ser_clk && !prev_clk) begin
                got = {got[6:0], ser_data};
                nbits++;
            end
            prev_clk = ser_clk;
            if (cyc == ra_cyc)  req = ra_val;
            if (cyc == rb_cyc)  req = rb_val;
            if (cyc == rdy_on)  peer_ready = 1'b1;
            if (cyc == rdy_off) peer_ready = 1'b0;
        end
        check_val({tag, "_cycle"}, cyc, exp_cyc);
        check_val({tag, "_pulse"}, {28'd0, done, err},
                  abort ? {28'd0, 2'b00, exp_owner} : {28'd0, exp_owner, 2'b00});
        check_val({tag, "_endgrant"}, {30'd0, grant}, {30'd0, exp_owner});
        check_val({tag, "_endlines"}, {30'd0, ser_rdy, ser_clk}, 32'd0);
        if (abort) begin
            check_val({tag, "_rdycnt"}, rdy_cnt, 32'd255);
            check_val({tag, "_nbits"}, nbits, 32'd0);
        end else begin
            check_val({tag, "_nbits"}, nbits, 32'd8);
            check_val({tag, "_byte"}, {24'd0, got}, {24'd0, exp_byte});
        end
        tick();
        check_val({tag, "_idle"}, {28'd0, grant, busy, done[0] | done[1] | err[0] | err[1]}, 32'd0);
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        rst_n      = 1'b0;
        req        = 2'b00;
        data0      = 8'h00;
        data1      = 8'h00;
        peer_ready = 1'b0;
        tick();
        tick();
        check_val("reset_outputs", {23'd0, grant, done, err, busy, ser_data, ser_clk, ser_rdy}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("post_reset_idle", {23'd0, grant, done, err, busy, ser_data, ser_clk, ser_rdy}, 32'd0);

        // Single scanner transfer of 0xA5 with peer already ready
        data0      = 8'hA5;
        peer_ready = 1'b1;
        req        = 2'b01;
        run_xfer("t1", 2'b01, 8'hA5, 34, 1'b0, 1, 2'b00, 0, 2'b00, 0, 0);

        // Both requesting from reset: 0, 1, 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        data0 = 8'h5A;
        data1 = 8'h3C;
        req   = 2'b11;
        run_xfer("t2a", 2'b01, 8'h5A, 34, 1'b0, 0, 2'b00, 0, 2'b00, 0, 0);
        run_xfer("t2b", 2'b10, 8'h3C, 34, 1'b0, 0, 2'b00, 0, 2'b00, 0, 0);
        run_xfer("t2c", 2'b01, 8'h5A, 34, 1'b0, 0, 2'b00, 0, 2'b00, 0, 0);
        req = 2'b00;
        tick();
        check_val("t2_release", {30'd0, grant}, 32'd0);

        // Transfer center times out; the following tie goes to the scanner
        peer_ready = 1'b0;
        req        = 2'b10;
        run_xfer("t3", 2'b10, 8'h00, 256, 1'b1, 1, 2'b00, 0, 2'b00, 0, 0);
        data0      = 8'hE7;
        peer_ready = 1'b1;
        req        = 2'b11;
        run_xfer("t3tie", 2'b01, 8'hE7, 34, 1'b0, 1, 2'b00, 0, 2'b00, 0, 0);

        // Late peer_ready, dropped again during bit 4
        data0      = 8'hC3;
        peer_ready = 1'b0;
        req        = 2'b01;
        run_xfer("t4", 2'b01, 8'hC3, 44, 1'b0, 1, 2'b00, 0, 2'b00, 11, 29);

        // Reset during bit 3, then a fresh byte
        data0      = 8'h96;
        peer_ready = 1'b1;
        req        = 2'b01;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 0) req = 2'b00;
        end
        check_val("t5_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("t5_async_reset", {23'd0, grant, done, err, busy, ser_data, ser_clk, ser_rdy}, 32'd0);
        tick();
        rst_n = 1'b1;
        data0 = 8'h69;
        req   = 2'b01;
        run_xfer("t5", 2'b01, 8'h69, 34, 1'b0, 1, 2'b00, 0, 2'b00, 0, 0);

        // Owner drops req after grant; other requester raises and withdraws mid-transfer
        data0 = 8'h81;
        data1 = 8'hFF;
        req   = 2'b01;
        run_xfer("t6", 2'b01, 8'h81, 34, 1'b0, 3, 2'b10, 8, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t6_no_grant", {29'd0, grant, busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
